// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-prediction types and constants for the predictor and the resolve queue
package bp_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } brq_entry_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] STK = 2'b11;
endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: circular buffer with push, pop, flush (head snaps to tail), occupancy and full/empty
module brq_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  assign dout = mem[head];
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  // pointer and occupancy update; flush drops every entry from head to tail
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= tail;
      count <= '0;
    end else begin
      head <= head + PTR_W'(pop);
      tail <= tail + PTR_W'(push);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  // entry storage is intentionally not reset
  always_ff @(posedge clk)
    if (push) mem[tail] <= din;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order predicted-branch queue with training update, mispredict redirect and flush; BRQ_STATS_EN adds saturating resolve/mispredict counters
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_pc,
  input  logic             push_pred,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   count,
`ifdef BRQ_STATS_EN
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispred,
`endif
  output logic             underflow_err
);
  brq_entry_t head_entry;
  logic full, empty, do_pop, mis;
  assign push_ready = !full;
  assign do_pop = resolve_valid && !empty;
  assign mis = do_pop && (head_entry.pred != resolve_taken);
  brq_fifo #(.W($bits(brq_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_valid && push_ready && !mis),
    .pop(do_pop),
    .flush(mis),
    .din({push_pc, push_pred}),
    .dout(head_entry),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // one-cycle training/redirect outputs registered from the resolving head entry
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      upd_valid <= 1'b0;
      upd_pc <= '0;
      upd_taken <= 1'b0;
      mispredict <= 1'b0;
      redirect_pc <= '0;
      underflow_err <= 1'b0;
    end else begin
      upd_valid <= do_pop;
      mispredict <= mis;
      underflow_err <= underflow_err || (resolve_valid && empty);
      if (do_pop) begin
        upd_pc <= head_entry.pc;
        upd_taken <= resolve_taken;
        redirect_pc <= resolve_taken ? resolve_target : head_entry.pc + INSTR_BYTES;
      end
    end
`ifdef BRQ_STATS_EN
  // saturating counters that step with the upd_valid pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred <= '0;
    end else begin
      if (do_pop && stat_resolved != '1) stat_resolved <= stat_resolved + 32'd1;
      if (mis && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
    end
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;
  logic clk = 1'b0, reset = 1'b1;
  logic push_valid = 0, push_pred = 0, resolve_valid = 0, resolve_taken = 0;
  logic [31:0] push_pc = 0, resolve_target = 0;
  logic push_ready, upd_valid, upd_taken, mispredict, underflow_err;
  logic [31:0] upd_pc, redirect_pc;
  logic [3:0] count;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif
  int passed = 0, total = 0;

  branch_resolve_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc), .push_pred(push_pred),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count),
`ifdef BRQ_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] pc, input logic pred);
    push_valid = v;
    push_pc = pc;
    push_pred = pred;
  endtask

  task automatic set_res(input logic v, input logic taken, input logic [31:0] tgt);
    resolve_valid = v;
    resolve_taken = taken;
    resolve_target = tgt;
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_underflow", 32'(underflow_err), 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    #3 reset = 1'b0;
    tick;
    // correct taken prediction
    set_push(1, 32'h100, 1);
    tick;
    chk("t1_count1", 32'(count), 1);
    set_push(0, 0, 0);
    set_res(1, 1, 32'h200);
    tick;
    chk("t1_upd_valid", 32'(upd_valid), 1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_upd_taken", 32'(upd_taken), 1);
    chk("t1_mispredict", 32'(mispredict), 0);
    chk("t1_redirect", redirect_pc, 32'h200);
    chk("t1_count0", 32'(count), 0);
    set_res(0, 0, 0);
    tick;
    chk("t1_pulse_end", 32'(upd_valid), 0);
    // mispredict flushes younger entry
    set_push(1, 32'h40, 1);
    tick;
    set_push(1, 32'h44, 0);
    tick;
    chk("t2_count2", 32'(count), 2);
    set_push(0, 0, 0);
    set_res(1, 0, 32'h999);
    tick;
    chk("t2_mispredict", 32'(mispredict), 1);
    chk("t2_upd_pc", upd_pc, 32'h40);
    chk("t2_redirect", redirect_pc, 32'h44);
    chk("t2_count0", 32'(count), 0);
    set_res(0, 0, 0);
    tick;
    chk("t2_misp_end", 32'(mispredict), 0);
    // resolve on empty queue: 0x44 is gone, underflow becomes sticky
    set_res(1, 0, 0);
    tick;
    chk("t4_no_upd", 32'(upd_valid), 0);
    chk("t4_underflow", 32'(underflow_err), 1);
    chk("t4_count", 32'(count), 0);
    set_res(0, 0, 0);
    // fill to DEPTH
    for (int i = 0; i < 8; i++) begin
      set_push(1, 32'h1000 + 32'(4 * i), 1);
      tick;
    end
    chk("t3_full_count", 32'(count), 8);
    chk("t3_not_ready", 32'(push_ready), 0);
    set_push(1, 32'h2000, 0);
    tick;
    chk("t3_held", 32'(count), 8);
    set_res(1, 1, 32'h3000);
    tick;
    chk("t3_pr_upd", 32'(upd_valid), 1);
    chk("t3_pr_pc", upd_pc, 32'h1000);
    chk("t3_pr_misp", 32'(mispredict), 0);
    chk("t3_pr_count", 32'(count), 7);
    chk("t3_ready", 32'(push_ready), 1);
    set_push(0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("t3_drain_pc", upd_pc, 32'h1000 + 32'(4 * i));
    end
    set_res(0, 0, 0);
    chk("t3_drained", 32'(count), 0);
    chk("t4_sticky", 32'(underflow_err), 1);
    // fall-through wraps to zero
    set_push(1, 32'hFFFF_FFFC, 1);
    tick;
    set_push(0, 0, 0);
    set_res(1, 0, 32'h1234);
    tick;
    chk("t5_misp", 32'(mispredict), 1);
    chk("t5_redirect", redirect_pc, 32'h0);
    // push coinciding with a mispredicting resolve is discarded
    set_res(0, 0, 0);
    set_push(1, 32'h600, 0);
    tick;
    set_push(1, 32'h604, 0);
    set_res(1, 1, 32'h700);
    tick;
    chk("t5_flush_misp", 32'(mispredict), 1);
    chk("t5_flush_redir", redirect_pc, 32'h700);
    chk("t5_flush_count", 32'(count), 0);
    // wrap: 20 overlapped push/resolve pairs keep order
    set_res(0, 0, 0);
    set_push(1, 32'h8000, 0);
    tick;
    for (int i = 1; i < 20; i++) begin
      set_push(1, 32'h8000 + 32'(8 * i), 0);
      set_res(1, 0, 0);
      tick;
      chk("t5_wrap_pc", upd_pc, 32'h8000 + 32'(8 * (i - 1)));
      chk("t5_wrap_count", 32'(count), 1);
    end
    set_push(0, 0, 0);
    tick;
    chk("t5_wrap_last", upd_pc, 32'h8000 + 32'(8 * 19));
    chk("t5_wrap_misp", 32'(mispredict), 0);
    set_res(0, 0, 0);
    // async reset with a pending pulse
    for (int i = 0; i < 6; i++) begin
      set_push(1, 32'hA00 + 32'(4 * i), 1);
      tick;
    end
    set_push(0, 0, 0);
    set_res(1, 1, 32'hB00);
    tick;
    chk("t6_pre_count", 32'(count), 5);
    chk("t6_pre_upd", 32'(upd_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_upd_valid", 32'(upd_valid), 0);
    chk("t6_misp", 32'(mispredict), 0);
    chk("t6_underflow", 32'(underflow_err), 0);
`ifdef BRQ_STATS_EN
    chk("t6_stat_res", stat_resolved, 0);
    chk("t6_stat_mis", stat_mispred, 0);
`endif
    set_res(0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
